// File: rtl/pulse_synth_pkg.sv
// Shared widths, states and limits for the synthetic pulse source
// and the downstream FIR / heart-rate blocks.
package pulse_synth_pkg;

  localparam int TPL_LEN   = 32;
  localparam int TPL_IDX_W = 5;
  localparam int SAMPLE_W  = 9;
  localparam int PERIOD_W  = 11;
  localparam int ACC_W     = SAMPLE_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = 10'sd255;
  localparam logic signed [ACC_W-1:0] SAT_LO = -10'sd256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_REST
  } state_e;

  function automatic logic signed [SAMPLE_W-1:0] sat_sample(
    input logic signed [ACC_W-1:0] v
  );
    if (v > SAT_HI) return SAMPLE_W'(SAT_HI);
    if (v < SAT_LO) return SAMPLE_W'(SAT_LO);
    return SAMPLE_W'(v);
  endfunction

endpackage

// File: rtl/pulse_synth_rom.sv
// Pulse shape ROM: linear rise to 200 at index 8,
// then a slow linear decay to -7 at index 31.
module pulse_template_rom
  import pulse_synth_pkg::*;
(
  input  logic        [TPL_IDX_W-1:0] idx,
  output logic signed [SAMPLE_W-1:0]  coef
);

  always_comb begin
    coef = '0;
    unique case (idx)
      5'd0:  coef = 9'sd0;
      5'd1:  coef = 9'sd25;
      5'd2:  coef = 9'sd50;
      5'd3:  coef = 9'sd75;
      5'd4:  coef = 9'sd100;
      5'd5:  coef = 9'sd125;
      5'd6:  coef = 9'sd150;
      5'd7:  coef = 9'sd175;
      5'd8:  coef = 9'sd200;
      5'd9:  coef = 9'sd191;
      5'd10: coef = 9'sd182;
      5'd11: coef = 9'sd173;
      5'd12: coef = 9'sd164;
      5'd13: coef = 9'sd155;
      5'd14: coef = 9'sd146;
      5'd15: coef = 9'sd137;
      5'd16: coef = 9'sd128;
      5'd17: coef = 9'sd119;
      5'd18: coef = 9'sd110;
      5'd19: coef = 9'sd101;
      5'd20: coef = 9'sd92;
      5'd21: coef = 9'sd83;
      5'd22: coef = 9'sd74;
      5'd23: coef = 9'sd65;
      5'd24: coef = 9'sd56;
      5'd25: coef = 9'sd47;
      5'd26: coef = 9'sd38;
      5'd27: coef = 9'sd29;
      5'd28: coef = 9'sd20;
      5'd29: coef = 9'sd11;
      5'd30: coef = 9'sd2;
      5'd31: coef = -9'sd7;
    endcase
  end

endmodule

// File: rtl/pulse_synth.sv
// Synthetic heartbeat waveform source: one signed sample per
// sample period, a beat strobe at each pulse start, optional noise.
module pulse_synth
  import pulse_synth_pkg::*;
#(
  parameter int         CLKS_PER_SAMPLE = 650000,
  parameter int         TEMPLATE_LEN    = 32,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic        [PERIOD_W-1:0] period,
  input  logic        [1:0]          gain_shift,
  input  logic                       noise_en,
  output logic                       ready,
  output logic signed [SAMPLE_W-1:0] x,
  output logic                       beat
);

  localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [TPL_IDX_W-1:0] TIDX_LAST =
    TPL_IDX_W'(TEMPLATE_LEN - 1);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD =
    PERIOD_W'(TEMPLATE_LEN);

  state_e                      state_q, state_d;
  logic        [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic        [PERIOD_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic        [PERIOD_W-1:0]  eff_q, eff_d;
  logic        [TPL_IDX_W-1:0] tidx_q, tidx_d;
  logic        [7:0]           lfsr_q, lfsr_d;
  logic                        ready_q, ready_d;
  logic                        beat_q, beat_d;
  logic signed [SAMPLE_W-1:0]  x_q, x_d;

  logic                        tick;
  logic                        wrap;
  logic                        active;
  logic        [PERIOD_W-1:0]  period_eff;
  logic signed [SAMPLE_W-1:0]  rom_coef;
  logic signed [SAMPLE_W-1:0]  tpl_val;
  logic signed [ACC_W-1:0]     s_ext;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [ACC_W-1:0]     noise;
  logic signed [ACC_W-1:0]     sum;
  logic        [7:0]           lfsr_next;

  pulse_template_rom u_rom (
    .idx  (tidx_q),
    .coef (rom_coef)
  );

  always_comb begin
    tick   = (clk_cnt_q == CNT_LAST);
    wrap   = (beat_cnt_q == eff_q - PERIOD_W'(1));
    active = (state_q == ST_PULSE) || (state_q == ST_REST);
    period_eff = (period < MIN_PERIOD) ? MIN_PERIOD : period;
    tpl_val = (state_q == ST_PULSE) ? rom_coef : '0;
    s_ext   = ACC_W'(tpl_val);
    shifted = s_ext >>> gain_shift;
    noise   = noise_en ? ACC_W'($signed(lfsr_q[3:0])) : '0;
    sum     = shifted + noise;
    // Fibonacci taps 8,6,5,4
    lfsr_next = {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    beat_cnt_d = beat_cnt_q;
    tidx_d     = tidx_q;
    eff_d      = eff_q;
    lfsr_d     = lfsr_q;
    x_d        = x_q;
    ready_d    = 1'b0;
    beat_d     = 1'b0;
    if (!enable || !active) begin
      state_d    = enable ? ST_PULSE : ST_IDLE;
      clk_cnt_d  = '0;
      beat_cnt_d = '0;
      tidx_d     = '0;
      x_d        = '0;
    end else if (!tick) begin
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
    end else begin
      clk_cnt_d  = '0;
      ready_d    = 1'b1;
      lfsr_d     = lfsr_next;
      x_d        = sat_sample(sum);
      beat_cnt_d = wrap ? '0 : beat_cnt_q + PERIOD_W'(1);
      if (state_q == ST_PULSE) begin
        tidx_d = tidx_q + TPL_IDX_W'(1);
        if (tidx_q == '0) begin
          beat_d = 1'b1;
          eff_d  = period_eff;
        end
      end
      if (wrap) begin
        state_d = ST_PULSE;
        tidx_d  = '0;
      end else if (state_q == ST_PULSE && tidx_q == TIDX_LAST) begin
        state_d = ST_REST;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clk_cnt_q  <= '0;
      beat_cnt_q <= '0;
      tidx_q     <= '0;
      eff_q      <= MIN_PERIOD;
      lfsr_q     <= LFSR_SEED;
      ready_q    <= 1'b0;
      beat_q     <= 1'b0;
      x_q        <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      tidx_q     <= tidx_d;
      eff_q      <= eff_d;
      lfsr_q     <= lfsr_d;
      ready_q    <= ready_d;
      beat_q     <= beat_d;
      x_q        <= x_d;
    end
  end

  assign ready = ready_q;
  assign beat  = beat_q;
  assign x     = x_q;

endmodule

// File: tb/tb_pulse_synth.sv
// Scoreboard bench for pulse_synth: expected samples are queued
// as stimulus is set up and checked on every ready strobe.
module tb_pulse_synth;

  localparam int CPS = 40;

  typedef struct {
    int x;
    int b;
  } exp_t;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic        [10:0] period = 11'd100;
  logic        [1:0]  gain_shift = 2'd0;
  logic               noise_en = 1'b0;
  logic               ready;
  logic               beat;
  logic signed [8:0]  x;

  exp_t exp_q[$];
  int   gap_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_ready = 0;
  int   cyc = 0;
  int   last_rdy = 0;
  int   last_beat = 0;
  bit   have_rdy = 1'b0;
  bit   have_beat = 1'b0;
  bit   tol = 1'b0;

  pulse_synth #(
    .CLKS_PER_SAMPLE (CPS),
    .TEMPLATE_LEN    (32),
    .LFSR_SEED       (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .period     (period),
    .gain_shift (gain_shift),
    .noise_en   (noise_en),
    .ready      (ready),
    .x          (x),
    .beat       (beat)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int tmpl(input int i);
    return (i <= 8) ? 25 * i : 200 - 9 * (i - 8);
  endfunction

  task automatic push_beat(input int eff, input int g, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.x = (k < 32) ? (tmpl(k) >>> g) : 0;
      e.b = (k == 0) ? 1 : 0;
      exp_q.push_back(e);
    end
    if (n == eff) gap_q.push_back(eff);
  endtask

  task automatic clear_track();
    exp_q.delete();
    gap_q.delete();
    have_rdy = 1'b0;
    have_beat = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clock);
    reset = 1'b1;
    clear_track();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      chk("rst_ready", int'(ready), 0);
      chk("rst_beat", int'(beat), 0);
      chk("rst_x", int'(x), 0);
    end
    reset = 1'b0;
  endtask

  task automatic wait_rdy(input int target, input int max_cyc);
    int k = 0;
    while (n_ready < target && k < max_cyc) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (n_ready < target) chk("wait_rdy_timeout", n_ready, target);
  endtask

  task automatic wait_empty(input int max_cyc);
    int k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic first_latency(input string tag);
    int k = 0;
    while (!ready && k < 4 * CPS) begin
      @(negedge clock);
      k++;
    end
    // one clock to leave IDLE, then a full sample period
    chk(tag, k, CPS + 1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    int   d;
    if (beat && !ready) chk("beat_without_ready", int'(ready), 1);
    if (ready) begin
      n_ready++;
      if (have_rdy) chk("ready_gap", cyc - last_rdy, CPS);
      have_rdy = 1'b1;
      last_rdy = cyc;
      if (beat) begin
        if (have_beat && gap_q.size() > 0)
          chk("beat_gap", cyc - last_beat, gap_q.pop_front() * CPS);
        have_beat = 1'b1;
        last_beat = cyc;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (tol) begin
          d = int'(x) - e.x;
          chk("x_noise_window", int'(d >= -8 && d <= 8), 1);
        end else begin
          chk("x", int'(x), e.x);
        end
        chk("beat", int'(beat), e.b);
      end
    end
  end

  initial begin
    int base;
    int r0;

    // Reset with enable high, long beats, mid-beat period change
    enable = 1'b1;
    period = 11'd100;
    do_reset(3);
    push_beat(100, 0, 100);
    push_beat(100, 0, 100);
    push_beat(100, 0, 100);
    push_beat(50, 0, 50);
    first_latency("first_ready_latency");
    base = n_ready - 1;
    wait_rdy(base + 240, 260 * CPS);
    period = 11'd50;
    wait_empty(150 * CPS);

    // Short period clamps to back-to-back 32-sample pulses
    period = 11'd10;
    do_reset(2);
    push_beat(32, 0, 32);
    push_beat(32, 0, 32);
    push_beat(32, 0, 32);
    wait_empty(120 * CPS);

    // Gain shift of 3
    gain_shift = 2'd3;
    do_reset(2);
    push_beat(32, 3, 32);
    wait_empty(40 * CPS);

    // Noise enabled at unity gain
    gain_shift = 2'd0;
    noise_en = 1'b1;
    tol = 1'b1;
    do_reset(2);
    push_beat(32, 0, 32);
    push_beat(32, 0, 32);
    wait_empty(80 * CPS);
    tol = 1'b0;
    noise_en = 1'b0;

    // Drop enable mid-pulse, then restart
    period = 11'd100;
    do_reset(2);
    base = n_ready;
    push_beat(100, 0, 6);
    wait_rdy(base + 6, 10 * CPS);
    enable = 1'b0;
    @(negedge clock);
    chk("disable_x", int'(x), 0);
    chk("disable_ready", int'(ready), 0);
    clear_track();
    r0 = n_ready;
    repeat (100) @(negedge clock);
    chk("idle_ready_count", n_ready - r0, 0);
    chk("idle_x", int'(x), 0);
    push_beat(100, 0, 8);
    enable = 1'b1;
    first_latency("reenable_latency");
    wait_empty(20 * CPS);

    // Reset during REST restores outputs and the LFSR seed
    noise_en = 1'b1;
    tol = 1'b1;
    do_reset(2);
    base = n_ready;
    push_beat(100, 0, 50);
    wait_rdy(base + 50, 60 * CPS);
    chk("lfsr_advanced", int'(dut.lfsr_q != 8'hA5), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrest_rst_ready", int'(ready), 0);
    chk("midrest_rst_beat", int'(beat), 0);
    chk("midrest_rst_x", int'(x), 0);
    chk("midrest_rst_lfsr", int'(dut.lfsr_q), 8'hA5);
    clear_track();
    tol = 1'b0;
    enable = 1'b0;
    reset = 1'b0;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
